// File: rtl/sound_event_sequencer.sv
// Multi-event tone sequencer for the snake game: NUM_EV fixed-priority event lines, one timed
// square-wave tone per event, preemption by higher priority, one-deep pending slot, button mute.
module sound_event_sequencer #(
   parameter int NUM_EV    = 4,
   parameter int DUR_CYC   = 8,
   parameter int BASE_HALF = 2,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      nRst_i,
   input  logic                      button_i,
   input  logic [NUM_EV-1:0]         ev_i,
   output logic                      playSound,
   output logic                      tone_o,
   output logic                      mode_o,
   output logic [$clog2(NUM_EV)-1:0] chan_o
);
   localparam int CH_W = $clog2(NUM_EV);
   localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DUR_CYC - 1);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t              state_q, state_d;
   logic                mode_q, mode_d;
   logic                tone_q, tone_d;
   logic [CH_W-1:0]     chan_q, chan_d;
   logic [CNT_W-1:0]    dur_q, dur_d;
   logic [CNT_W-1:0]    half_q, half_d;
   logic                pend_v_q, pend_v_d;
   logic [CH_W-1:0]     pend_c_q, pend_c_d;
   logic [NUM_EV-1:0]   ev_q, ev_d;
   logic                btn_q, btn_d;

   logic [NUM_EV-1:0]   req, rest;
   logic                press;
   logic [CH_W-1:0]     k, k2;
   logic [CNT_W-1:0]    half_lim;
   logic                start;
   logic [CH_W-1:0]     start_ch;

   function automatic logic [CH_W-1:0] first_set(input logic [NUM_EV-1:0] v);
      logic found;
      first_set = '0;
      found     = 1'b0;
      for (int unsigned i = 0; i < NUM_EV; i++) begin
         if (v[i] && !found) begin
            first_set = CH_W'(i);
            found     = 1'b1;
         end
      end
   endfunction

   always_ff @(posedge clk or negedge nRst_i) begin
      if (!nRst_i) begin
         state_q  <= IDLE;
         mode_q   <= 1'b1;
         tone_q   <= 1'b0;
         chan_q   <= '0;
         dur_q    <= '0;
         half_q   <= '0;
         pend_v_q <= 1'b0;
         pend_c_q <= '0;
         ev_q     <= '0;
         btn_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         tone_q   <= tone_d;
         chan_q   <= chan_d;
         dur_q    <= dur_d;
         half_q   <= half_d;
         pend_v_q <= pend_v_d;
         pend_c_q <= pend_c_d;
         ev_q     <= ev_d;
         btn_q    <= btn_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      tone_d   = tone_q;
      chan_d   = chan_q;
      dur_d    = dur_q;
      half_d   = half_q;
      pend_v_d = pend_v_q;
      pend_c_d = pend_c_q;
      ev_d     = ev_i;
      btn_d    = button_i;
      start    = 1'b0;
      start_ch = '0;

      req      = ev_i & ~ev_q;
      press    = button_i & ~btn_q;
      k        = first_set(req);
      rest     = req;
      rest[k]  = 1'b0;
      k2       = first_set(rest);
      half_lim = CNT_W'(BASE_HALF * (int'(chan_q) + 1) - 1);

      if (press) begin
         mode_d = ~mode_q;
         if (mode_q) begin
            state_d  = IDLE;
            tone_d   = 1'b0;
            pend_v_d = 1'b0;
         end
      end else if (mode_q) begin
         unique case (state_q)
            IDLE: begin
               if (|req) begin
                  start    = 1'b1;
                  start_ch = k;
                  pend_v_d = |rest;
                  pend_c_d = k2;
               end
            end
            PLAY: begin
               if (|req && (k < chan_q)) begin
                  start    = 1'b1;
                  start_ch = k;
                  if (|rest && (!pend_v_q || (k2 < pend_c_q))) begin
                     pend_v_d = 1'b1;
                     pend_c_d = k2;
                  end
               end else begin
                  if (|req && (!pend_v_q || (k < pend_c_q))) begin
                     pend_v_d = 1'b1;
                     pend_c_d = k;
                  end
                  // Pending slot already includes this cycle's request when the tone ends.
                  if (dur_q == DUR_LAST) begin
                     if (pend_v_d) begin
                        start    = 1'b1;
                        start_ch = pend_c_d;
                        pend_v_d = 1'b0;
                     end else begin
                        state_d = IDLE;
                        tone_d  = 1'b0;
                     end
                  end else begin
                     dur_d = dur_q + CNT_W'(1);
                     if (half_q == half_lim) begin
                        half_d = '0;
                        tone_d = ~tone_q;
                     end else begin
                        half_d = half_q + CNT_W'(1);
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (start) begin
         state_d = PLAY;
         chan_d  = start_ch;
         tone_d  = 1'b1;
         dur_d   = '0;
         half_d  = '0;
      end
   end

   always_comb begin
      playSound = (state_q == PLAY);
      tone_o    = tone_q;
      mode_o    = mode_q;
      chan_o    = chan_q;
   end
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Scoreboard bench for sound_event_sequencer: stimulus queues the expected tone/channel of every
// cycle with playSound high; the monitor pops one entry per such cycle and compares.
module tb_sound_event_sequencer;
   logic       clk;
   logic       nRst_i;
   logic       button_i;
   logic [3:0] ev_i;
   logic       playSound;
   logic       tone_o;
   logic       mode_o;
   logic [1:0] chan_o;

   typedef struct {
      logic       tone;
      logic [1:0] chan;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   sound_event_sequencer #(
      .NUM_EV   (4),
      .DUR_CYC  (8),
      .BASE_HALF(2),
      .CNT_W    (16)
   ) dut (
      .clk      (clk),
      .nRst_i   (nRst_i),
      .button_i (button_i),
      .ev_i     (ev_i),
      .playSound(playSound),
      .tone_o   (tone_o),
      .mode_o   (mode_o),
      .chan_o   (chan_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic push(input logic t, input logic [1:0] c, input int n);
      exp_t e;
      e.tone = t;
      e.chan = c;
      for (int i = 0; i < n; i++) sb_q.push_back(e);
   endtask

   // Monitor: every cycle the DUT presents a tone must match the next queued expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (playSound) begin
         n_total++;
         if (sb_q.size() == 0) begin
            $display("FAIL tone_unexpected: playSound=1 chan=%0d tone=%0d, expected no sound",
                     chan_o, tone_o);
         end else begin
            e = sb_q.pop_front();
            if (tone_o === e.tone && chan_o === e.chan) n_pass++;
            else $display("FAIL tone_stream: got tone=%0b chan=%0d, expected tone=%0b chan=%0d",
                          tone_o, chan_o, e.tone, e.chan);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      nRst_i   = 1'b0;
      button_i = 1'b0;
      ev_i     = '0;

      // 1: reset values during and after reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_mode",  mode_o,    1);
      check("rst_play",  playSound, 0);
      check("rst_tone",  tone_o,    0);
      check("rst_chan",  chan_o,    0);
      @(negedge clk) nRst_i = 1'b1;
      @(posedge clk);
      #1;
      check("post_mode", mode_o,    1);
      check("post_play", playSound, 0);
      check("post_tone", tone_o,    0);
      check("post_chan", chan_o,    0);

      // 2: single event on channel 1, half-period 4
      @(negedge clk);
      ev_i = 4'b0010;
      push(1'b1, 2'd1, 4);
      push(1'b0, 2'd1, 4);
      @(negedge clk) ev_i = '0;
      repeat (12) @(negedge clk);
      check("t2_drain", sb_q.size(), 0);

      // 3: channel 2 preempted by channel 0 three cycles in
      ev_i = 4'b0100;
      push(1'b1, 2'd2, 3);
      push(1'b1, 2'd0, 2); push(1'b0, 2'd0, 2);
      push(1'b1, 2'd0, 2); push(1'b0, 2'd0, 2);
      @(negedge clk) ev_i = '0;
      @(negedge clk);
      @(negedge clk) ev_i = 4'b0001;
      @(negedge clk) ev_i = '0;
      repeat (12) @(negedge clk);
      check("t3_drain", sb_q.size(), 0);
      check("t3_idle", playSound, 0);

      // 4: simultaneous 0 and 3; 3 is pending and follows without a gap
      ev_i = 4'b1001;
      push(1'b1, 2'd0, 2); push(1'b0, 2'd0, 2);
      push(1'b1, 2'd0, 2); push(1'b0, 2'd0, 2);
      push(1'b1, 2'd3, 8);
      @(negedge clk) ev_i = '0;
      repeat (20) @(negedge clk);
      check("t4_drain", sb_q.size(), 0);

      // 5: mute during play, held button, events while OFF, unmute with simultaneous req
      ev_i = 4'b0010;
      push(1'b1, 2'd1, 2);
      @(negedge clk) ev_i = '0;
      @(negedge clk) button_i = 1'b1;
      @(posedge clk);
      #1;
      check("t5_mode_off", mode_o,    0);
      check("t5_play_off", playSound, 0);
      check("t5_tone_off", tone_o,    0);
      check("t5_chan_held", chan_o,   1);
      @(negedge clk) ev_i = 4'b0001;
      @(negedge clk) ev_i = '0;
      repeat (3) @(negedge clk);
      check("t5_held_once", mode_o, 0);
      button_i = 1'b0;
      @(negedge clk);
      button_i = 1'b1;
      ev_i     = 4'b0100;
      @(posedge clk);
      #1;
      check("t5_mode_on", mode_o,    1);
      check("t5_btn_wins", playSound, 0);
      @(negedge clk);
      button_i = 1'b0;
      ev_i     = '0;
      repeat (12) @(negedge clk);
      check("t5_drain", sb_q.size(), 0);
      check("t5_quiet", playSound, 0);

      // 6: async reset mid-play with a pending channel
      ev_i = 4'b1001;
      push(1'b1, 2'd0, 2); push(1'b0, 2'd0, 1);
      @(negedge clk) ev_i = '0;
      @(negedge clk);
      @(negedge clk);
      #2 nRst_i = 1'b0;
      #1;
      check("t6_async_play", playSound, 0);
      check("t6_async_tone", tone_o,    0);
      check("t6_async_chan", chan_o,    0);
      check("t6_async_mode", mode_o,    1);
      @(negedge clk) nRst_i = 1'b1;
      repeat (12) @(negedge clk);
      check("t6_drain", sb_q.size(), 0);
      check("t6_quiet", playSound, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
